if_stage: RTL and testbench

- Instruction-fetch stage placed directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM word address.
- Captures the returned instruction into an IF/ID output register.
- Offers the captured instruction to decode with a valid/ready handshake, plus stall, branch/jump redirect (flush), and halt/resume control.

---
 rtl/if_stage.sv | 100 ++++++++++
 tb/tb_if_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, IF/ID register, redirect, stall and halt control.
// Optional perf counters (fetch_cnt, stall_cnt) enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc4,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    input  logic              resume,
    output logic              halted,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        valid_nx, cap, fire, load;

    assign fire      = out_valid & out_ready;
    assign load      = !out_valid | out_ready;
    assign imem_addr = pc[ADDR_W+1:2];

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        valid_nx = out_valid;
        cap      = 1'b0;
        case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (redirect_valid) begin
                    pc_nx    = redirect_pc & ~32'd3;
                    valid_nx = 1'b0;
                    if (halt) state_nx = HALT;
                end else if (halt) begin
                    state_nx = HALT;
                    if (fire) valid_nx = 1'b0;
                end else if (load) begin
                    cap      = 1'b1;
                    valid_nx = 1'b1;
                    pc_nx    = pc + 32'd4;
                end
            end
            HALT: begin
                // the held instruction drains to decode; nothing new is fetched
                if (fire) valid_nx = 1'b0;
                if (resume && !halt) state_nx = RUN;
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_inst  <= 32'h0;
            out_pc    <= 32'h0;
            out_pc4   <= 32'h0;
            halted    <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            out_valid <= valid_nx;
            halted    <= (state_nx == HALT);
            if (cap) begin
                out_inst <= imem_data;
                out_pc   <= pc;
                out_pc4  <= pc + 32'd4;
            end
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (fire) fetch_cnt <= fetch_cnt + 32'd1;
            if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign fetch_cnt = 32'h0;
    assign stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage against a cycle-level behavioural model.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_inst, out_pc, out_pc4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0, resume = 1'b0, halted;
    logic [31:0] fetch_cnt, stall_cnt;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_pc4(out_pc4), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .resume(resume), .halted(halted),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    assign imem_data = mem[imem_addr];

    typedef struct {logic [31:0] inst, pc, pc4;} exp_t;
    exp_t q[$];

    int checks = 0, errors = 0;
    int mode;               // 0 boot, 1 run, 2 halt
    logic [31:0] m_pc, m_fetch, m_stall;
    logic m_valid;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual %h required %h", n, a, e);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; mode = 0; m_valid = 1'b0; m_fetch = 0; m_stall = 0;
        q.delete();
    endtask

    // advance the model across one clock edge using the inputs held through it
    task automatic step();
        logic fired;
        fired = m_valid && out_ready;
        if (fired) m_fetch++;
        if (m_valid && !out_ready) m_stall++;
        if (mode == 0) mode = 1;
        else if (mode == 1) begin
            if (redirect_valid) begin
                m_pc = {redirect_pc[31:2], 2'b00};
                m_valid = 1'b0;
                q.delete();
                if (halt) mode = 2;
            end else if (halt) begin
                mode = 2;
                if (fired) m_valid = 1'b0;
            end else if (!m_valid || out_ready) begin
                q.push_back('{mem[m_pc[11:2]], m_pc, m_pc + 32'd4});
                m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (fired) m_valid = 1'b0;
            if (resume && !halt) mode = 1;
        end
    endtask

    task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic h, input logic rs);
        out_ready = r; redirect_valid = rv; redirect_pc = rpc; halt = h; resume = rs;
        @(posedge clk);
        #1 step();
    endtask

    task automatic chk_cnt();
`ifdef IF_STAGE_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_fetch);
        chk("stall_cnt", stall_cnt, m_stall);
`else
        chk("fetch_cnt_tied", fetch_cnt, 32'h0);
        chk("stall_cnt_tied", stall_cnt, 32'h0);
`endif
    endtask

    // asynchronous reset mid-cycle: outputs must clear before any clock edge
    task automatic do_reset();
        chk_cnt();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_pc4", out_pc4, 32'h0);
        chk("rst_halted", halted, 32'h0);
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        chk("valid", out_valid, m_valid);
        chk("imem_addr", imem_addr, m_pc[11:2]);
        chk("halted", halted, mode == 2);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL fire_without_expected actual pc %h required none", out_pc);
            end else begin
                e = q.pop_front();
                chk("out_inst", out_inst, e.inst);
                chk("out_pc", out_pc, e.pc);
                chk("out_pc4", out_pc4, e.pc4);
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        for (int k = 0; k < 1024; k++) mem[k] = 32'(k);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 32'h0000_0103, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 32'h0000_0200, 1, 0);
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 32'h0000_0FFC, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 32'hFFFF_FFFC, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 32'h0000_0040, 1, 0);
        cyc(1, 0, 0, 0, 1);
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom_range(1) ? $urandom : (32'hFFFF_FFF0 | ($urandom & 32'hF));
            cyc($urandom_range(3) != 0, $urandom_range(19) == 0, rpc,
                $urandom_range(29) == 0, $urandom_range(4) == 0);
            if ($urandom_range(499) == 0) do_reset();
        end
        chk_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
